// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding
// and one-hot {lt, eq, gt} result constants.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module chunk_compare #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    always_comb begin
        lt = (x < y);
        eq = (x == y);
        gt = (x > y);
    end

endmodule

// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator: scans captured operands CHUNK bits per
// cycle from the MSB chunk down and stops at the first differing chunk.
module seq_magnitude_compare
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      a,
    input  logic [WIDTH-1:0]                      b,
    input  logic                                  signed_mode,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  lt,
    output logic                                  eq,
    output logic                                  gt,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]      cycles
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
        $error("seq_magnitude_compare: WIDTH must be a multiple of CHUNK");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     cycles_q, cycles_d;
    logic [2:0]        res_q, res_d;
    logic [CHUNK-1:0]  x_sel, y_sel;
    logic              c_lt, c_eq, c_gt;

    always_comb begin
        x_sel = CHUNK'(a_q >> (CHUNK * k_q));
        y_sel = CHUNK'(b_q >> (CHUNK * k_q));
    end

    chunk_compare #(.CHUNK(CHUNK)) u_chunk (
        .x  (x_sel),
        .y  (y_sel),
        .lt (c_lt),
        .eq (c_eq),
        .gt (c_gt)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        cycles_d = cycles_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Flipping both MSBs maps two's-complement order onto unsigned order.
                    a_d = a;
                    b_d = b;
                    if (signed_mode) begin
                        a_d[WIDTH-1] = ~a[WIDTH-1];
                        b_d[WIDTH-1] = ~b[WIDTH-1];
                    end
                    k_d      = KW'(N - 1);
                    cycles_d = '0;
                    res_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                cycles_d = cycles_q + 1'b1;
                if (!c_eq) begin
                    res_d   = c_lt ? CMP_LT : (c_gt ? CMP_GT : CMP_EQ);
                    state_d = DONE;
                end else if (k_q == '0) begin
                    res_d   = CMP_EQ;
                    state_d = DONE;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            cycles_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            cycles_q <= cycles_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        lt        = (res_q == CMP_LT);
        eq        = (res_q == CMP_EQ);
        gt        = (res_q == CMP_GT);
        cycles    = cycles_q;
    end

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Bench for seq_magnitude_compare at 32/2 and 8/4 against an arithmetic
// reference of compare result and first-differing-chunk latency.
module tb_seq_magnitude_compare;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        lt32, eq32, gt32;
    logic [4:0]  cyc32;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        lt8, eq8, gt8;
    logic [1:0]  cyc8;

    int compared   = 0;
    int mismatched = 0;

    seq_magnitude_compare #(.WIDTH(32), .CHUNK(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .signed_mode(sm32), .out_valid(ov32),
        .out_ready(or32), .lt(lt32), .eq(eq32), .gt(gt32), .cycles(cyc32)
    );

    seq_magnitude_compare #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8),
        .out_ready(or8), .lt(lt8), .eq(eq8), .gt(gt8), .cycles(cyc8)
    );

    logic       sel8 = 1'b0;
    logic       cur_ir, cur_ov;
    logic [2:0] cur_res;
    int         cur_cyc;
    always_comb begin
        cur_ir  = sel8 ? ir8 : ir32;
        cur_ov  = sel8 ? ov8 : ov32;
        cur_res = sel8 ? {lt8, eq8, gt8} : {lt32, eq32, gt32};
        cur_cyc = sel8 ? int'(cyc8) : int'(cyc32);
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Result {lt,eq,gt} from signed/unsigned arithmetic; latency from the
    // highest differing bit position.
    task automatic ref_model(input int w, input int ch, input logic [31:0] ai,
                             input logic [31:0] bi, input bit s,
                             output logic [2:0] res, output int j);
        longint va, vb;
        logic [31:0] d;
        int n, h;
        n  = w / ch;
        va = longint'(ai);
        vb = longint'(bi);
        if (s && ai[w-1]) va = va - (longint'(1) << w);
        if (s && bi[w-1]) vb = vb - (longint'(1) << w);
        res = (va < vb) ? 3'b100 : ((va == vb) ? 3'b010 : 3'b001);
        d = ai ^ bi;
        h = -1;
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i] && h < 0) h = i;
        end
        j = (h < 0) ? n : n - h / ch;
    endtask

    task automatic op(input bit is8, input logic [31:0] ai_in, input logic [31:0] bi_in,
                      input bit s, input int hold, input bit keep_valid);
        logic [31:0] ai, bi;
        logic [2:0]  er;
        int          ej, lat;
        ai = is8 ? (ai_in & 32'hFF) : ai_in;
        bi = is8 ? (bi_in & 32'hFF) : bi_in;
        ref_model(is8 ? 8 : 32, is8 ? 4 : 2, ai, bi, s, er, ej);
        sel8 = is8;
        if (is8) begin iv8 = 1'b1; a8 = ai[7:0]; b8 = bi[7:0]; sm8 = s; end
        else     begin iv32 = 1'b1; a32 = ai; b32 = bi; sm32 = s; end
        #1;
        chk("in_ready_idle", cur_ir, 1);
        @(posedge clk); #1;
        if (!keep_valid) begin iv8 = 1'b0; iv32 = 1'b0; end
        lat = 0;
        while (!cur_ov && lat < 40) begin
            chk("in_ready_busy", cur_ir, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, ej);
        chk("result", cur_res, er);
        chk("cycles", cur_cyc, ej);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", cur_ov, 1);
            chk("hold_ready", cur_ir, 0);
            chk("hold_result", cur_res, er);
            chk("hold_cycles", cur_cyc, ej);
        end
        iv8 = 1'b0; iv32 = 1'b0;
        if (is8) or8 = 1'b1; else or32 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0; or32 = 1'b0;
        chk("post_hs_valid", cur_ov, 0);
        chk("post_hs_ready", cur_ir, 1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int sel_pat, stale;
        #1;
        chk("rst_in_ready", ir32, 1);
        chk("rst_out_valid", ov32, 0);
        chk("rst_res", {lt32, eq32, gt32}, 0);
        chk("rst_cycles", cyc32, 0);
        chk("rst_out_valid8", ov8, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 32'hC0000000, 32'h80000000, 0, 0, 0);
        op(0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        op(0, 32'hFFFFFFFF, 32'h00000001, 1, 0, 0);
        op(0, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0);
        op(0, 32'h00000002, 32'h00000001, 0, 0, 0);
        op(0, 32'h00000001, 32'h00000002, 0, 0, 0);
        op(0, 32'h80000000, 32'h7FFFFFFF, 1, 0, 0);
        op(0, 32'h12345678, 32'h12345600, 0, 5, 1);

        // Reset during the third scan cycle of an equal compare.
        sel8 = 1'b0;
        iv32 = 1'b1; a32 = 32'hDEADBEEF; b32 = 32'hDEADBEEF; sm32 = 1'b0;
        @(posedge clk); #1; iv32 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov32, 0);
        chk("midrst_res", {lt32, eq32, gt32}, 0);
        chk("midrst_cycles", cyc32, 0);
        chk("midrst_in_ready", ir32, 1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov32) stale++;
        end
        chk("no_stale_valid", stale, 0);
        op(0, 32'd5, 32'd9, 0, 0, 0);

        op(1, 32'hA5, 32'hA5, 0, 0, 0);
        op(1, 32'hFF, 32'h01, 1, 0, 0);
        op(1, 32'hFF, 32'h01, 0, 0, 0);
        op(1, 32'h12, 32'h13, 0, 2, 1);

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            sel_pat = $urandom_range(2);
            if (sel_pat == 0)      rb = ra;
            else if (sel_pat == 1) rb = ra ^ (32'h1 << $urandom_range(31));
            else                   rb = $urandom;
            op(t[0], ra, rb, $urandom_range(1) == 1, $urandom_range(3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
